dft_mac_engine: RTL and testbench
=================================

DFT_MAC_ENGINE -- requirements
Module: dft_mac_engine

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed width of each sample and twiddle component (twiddle format Q1.(DW-1)).
REQ-002 SHALL have parameter NLOG, default 12, meaning log2 of maximum transform length (buffer depth 2^NLOG complex words).
REQ-003 SHALL have parameter ACCW, default 2*DW+NLOG+1, meaning signed accumulator width per component.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port n_Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports cfg_n  input  NLOG+1  transform length N; cfg_inverse  input  1  1 = conjugate twiddles.
REQ-007 SHALL have ports start  input  1  begin job; busy  output  1; done  output  1  one-cycle pulse at job end; err  output  1  one-cycle pulse on illegal cfg_n.
REQ-008 SHALL have ports s_valid  input  1; s_ready  output  1; s_re, s_im  input  DW each  complex sample input stream.
REQ-009 SHALL have ports tw_addr  output  NLOG  twiddle index; tw_re, tw_im  input  DW each  W(tw_addr)=exp(-j*2*pi*tw_addr/N) from external ROM, valid exactly one cycle after tw_addr.
REQ-010 SHALL have ports m_valid  input-side  output  1; m_ready  input  1; m_re, m_im  output  DW each; m_k  output  NLOG  bin index; m_last  output  1  marks bin N-1.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, CALC, OUT; reset state IDLE.
REQ-012 SHALL in IDLE, on start with 2 <= cfg_n <= 2^NLOG, latch cfg_n and cfg_inverse, assert busy, enter LOAD next cycle.
REQ-013 SHALL on start with cfg_n < 2 or cfg_n > 2^NLOG pulse err one cycle, remain IDLE.
REQ-014 SHALL ignore start whenever busy=1; cfg_n/cfg_inverse changes during a job SHALL have no effect.
REQ-015 SHALL in LOAD hold s_ready=1, write sample n (n=0..N-1) to buffer on each s_valid&s_ready, enter CALC the cycle after the N-th accept; s_ready=0 in all other states.
REQ-016 SHALL in CALC, for current bin k, issue n=0..N-1 one per cycle: buffer read address n, tw_addr=(k*n) mod N computed incrementally (idx+=k; subtract N when idx+k >= N), no multiplier on index path.
REQ-017 SHALL form complex product one cycle after issue: re=x_re*w_re - x_im*w_im', im=x_re*w_im' + x_im*w_re, with w_im'=-tw_im when inverse latched else tw_im; accumulate sign-extended into ACCW registers cleared at n=0 of each bin.
REQ-018 SHALL enter OUT after the last product of bin k is accumulated (N+2 cycles after CALC entry for that bin).
REQ-019 SHALL in OUT drive m_valid=1, m_k=k, m_last=(k==N-1), m_re/m_im = saturate_DW((acc + 2^(DW-2)) >>> (DW-1)) per component; no 1/N scaling in either mode.
REQ-020 SHALL hold m_* stable while m_valid=1 and m_ready=0; on m_valid&m_ready SHALL go to CALC with k+1, or if k==N-1 go IDLE, deassert busy and pulse done same cycle.
REQ-021 SHALL saturate to +(2^(DW-1)-1) / -(2^(DW-1)); no wrap-around of outputs.
REQ-022 SHALL make tw_addr index N-1 the maximum issued; k=0 SHALL issue tw_addr=0 for all n.

Reset
REQ-023 SHALL on n_Reset=0 at any clock edge, including mid-LOAD/CALC/OUT, enter IDLE and drive busy, done, err, s_ready, m_valid, m_last=0, m_re, m_im, m_k, tw_addr=0, accumulators=0.
REQ-024 SHALL not clear buffer contents on reset; a new job fully overwrites samples 0..N-1 before use.

Verification
REQ-025 Bench ROM N=4: W0=(32767,0), W1=(0,-32767), W2=(-32767,0), W3=(0,32767); impulse x=[16384,0,0,0] -> bins 0..3 each (16384,0), m_last only on k=3, done one cycle after last handshake.
REQ-026 N=4, x=[8192,0,-8192,0] -> bins (0,0),(16384,0),(0,0),(16384,0); DC x=[16384]*4 -> bin0 re=32767 (saturated), others 0.
REQ-027 N=4, x=[0,16384,0,0]: forward bin1=(0,-16383); cfg_inverse=1 bin1=(0,16384).
REQ-028 m_ready held 0 for 10 cycles in OUT -> m_* unchanged, no further tw_addr activity; then released -> remaining bins correct.
REQ-029 start with cfg_n=1 and cfg_n=2^NLOG+1 -> err pulse, busy stays 0; start during busy -> ignored.
REQ-030 n_Reset asserted mid-CALC, then new N=8 job -> all outputs 0 during reset, second job results correct, no stale accumulation.

Source files
------------

// File: rtl/dft_mac_engine.sv
// Direct-form DFT: loads N complex samples, then computes each bin as a twiddle MAC over the buffer.
// Each bin takes N+2 cycles in CALC, then is held in OUT until m_ready; s_ready is high only while loading.
module dft_mac_engine #(
   parameter int DW   = 16,
   parameter int NLOG = 12,
   parameter int ACCW = 2*DW+NLOG+1
) (
   input  logic                 clk,
   input  logic                 n_Reset,
   input  logic [NLOG:0]        cfg_n,
   input  logic                 cfg_inverse,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic signed [DW-1:0] s_re,
   input  logic signed [DW-1:0] s_im,
   output logic [NLOG-1:0]      tw_addr,
   input  logic signed [DW-1:0] tw_re,
   input  logic signed [DW-1:0] tw_im,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic signed [DW-1:0] m_re,
   output logic signed [DW-1:0] m_im,
   output logic [NLOG-1:0]      m_k,
   output logic                 m_last
);
   localparam int PW = 2*DW+2;
   localparam logic [NLOG:0]           N_MAX   = {1'b1, {NLOG{1'b0}}};
   localparam logic [NLOG:0]           ONE_N   = (NLOG+1)'(1);
   localparam logic signed [ACCW-1:0]  RND     = ACCW'(2**(DW-2));
   localparam logic signed [ACCW-1:0]  SAT_MAX = ACCW'(2**(DW-1)-1);
   localparam logic signed [ACCW-1:0]  SAT_MIN = -SAT_MAX - ACCW'(1);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

   state_t                 st_q, st_d;
   logic [NLOG:0]          n_q, n_d, cnt_q, cnt_d;
   logic                   inv_q, inv_d;
   logic [NLOG-1:0]        k_q, k_d, tw_addr_q, tw_addr_d, m_k_q, m_k_d;
   logic                   busy_q, busy_d, done_q, done_d, err_q, err_d, s_ready_q, s_ready_d;
   logic                   m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic signed [DW-1:0]   m_re_q, m_re_d, m_im_q, m_im_d;
   logic                   v1_q, v1_d, f1_q, f1_d, v2_q, v2_d, f2_q, f2_d;
   logic signed [PW-1:0]   prod_re_q, prod_re_d, prod_im_q, prod_im_d;
   logic signed [ACCW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;

   logic [2*DW-1:0]        smp_mem [2**NLOG];
   logic [2*DW-1:0]        rd_dat_q;
   logic                   wr_en;
   logic signed [PW-1:0]   x_re_e, x_im_e, w_re_e, w_im_e;
   logic [NLOG:0]          tw_sum, tw_next, nm1;

   function automatic logic signed [DW-1:0] round_sat(input logic signed [ACCW-1:0] a);
      logic signed [ACCW-1:0] r;
      r = (a + RND) >>> (DW-1);
      if (r > SAT_MAX)      round_sat = SAT_MAX[DW-1:0];
      else if (r < SAT_MIN) round_sat = SAT_MIN[DW-1:0];
      else                  round_sat = r[DW-1:0];
   endfunction

   // Sample buffer is deliberately not reset; every job rewrites 0..N-1 before reading.
   assign wr_en = n_Reset && (st_q == LOAD) && s_valid && s_ready_q;
   always_ff @(posedge clk) begin
      if (wr_en) smp_mem[cnt_q[NLOG-1:0]] <= {s_re, s_im};
      rd_dat_q <= smp_mem[cnt_q[NLOG-1:0]];
   end

   assign x_re_e  = PW'($signed(rd_dat_q[2*DW-1:DW]));
   assign x_im_e  = PW'($signed(rd_dat_q[DW-1:0]));
   assign w_re_e  = PW'(tw_re);
   assign w_im_e  = inv_q ? -PW'(tw_im) : PW'(tw_im);
   assign nm1     = n_q - ONE_N;
   assign tw_sum  = {1'b0, tw_addr_q} + {1'b0, k_q};
   assign tw_next = (tw_sum >= n_q) ? (tw_sum - n_q) : tw_sum;

   always_comb begin
      st_d      = st_q;      n_d      = n_q;      inv_d    = inv_q;
      k_d       = k_q;       cnt_d    = cnt_q;    busy_d   = busy_q;
      done_d    = 1'b0;      err_d    = 1'b0;     s_ready_d = s_ready_q;
      tw_addr_d = tw_addr_q; m_valid_d = m_valid_q; m_last_d = m_last_q;
      m_re_d    = m_re_q;    m_im_d   = m_im_q;   m_k_d    = m_k_q;
      v1_d      = (st_q == CALC) && (cnt_q < n_q);
      f1_d      = (cnt_q == '0);
      v2_d      = v1_q;
      f2_d      = f1_q;
      prod_re_d = prod_re_q;
      prod_im_d = prod_im_q;
      acc_re_d  = acc_re_q;
      acc_im_d  = acc_im_q;
      if (v1_q) begin
         prod_re_d = x_re_e * w_re_e - x_im_e * w_im_e;
         prod_im_d = x_re_e * w_im_e + x_im_e * w_re_e;
      end
      // The first product of a bin replaces the accumulator instead of adding to it.
      if (v2_q) begin
         acc_re_d = (f2_q ? '0 : acc_re_q) + ACCW'(prod_re_q);
         acc_im_d = (f2_q ? '0 : acc_im_q) + ACCW'(prod_im_q);
      end
      case (st_q)
         IDLE: begin
            if (start) begin
               if (cfg_n >= (NLOG+1)'(2) && cfg_n <= N_MAX) begin
                  st_d      = LOAD;
                  n_d       = cfg_n;
                  inv_d     = cfg_inverse;
                  busy_d    = 1'b1;
                  s_ready_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (s_valid && s_ready_q) begin
               cnt_d = cnt_q + ONE_N;
               if (cnt_q == nm1) begin
                  st_d      = CALC;
                  s_ready_d = 1'b0;
                  cnt_d     = '0;
                  k_d       = '0;
                  tw_addr_d = '0;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + ONE_N;
            if (cnt_q < nm1) tw_addr_d = tw_next[NLOG-1:0];
            // Issue, buffer/ROM read and product register drain after N+2 cycles.
            if (cnt_q == n_q + ONE_N) begin
               st_d      = OUT;
               m_valid_d = 1'b1;
               m_k_d     = k_q;
               m_last_d  = ({1'b0, k_q} == nm1);
               m_re_d    = round_sat(acc_re_d);
               m_im_d    = round_sat(acc_im_d);
            end
         end
         OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if ({1'b0, k_q} == nm1) begin
                  st_d   = IDLE;
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  st_d      = CALC;
                  k_d       = k_q + NLOG'(1);
                  cnt_d     = '0;
                  tw_addr_d = '0;
               end
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_Reset) begin
         st_q      <= IDLE;  n_q      <= '0;   inv_q    <= 1'b0;
         k_q       <= '0;    cnt_q    <= '0;   busy_q   <= 1'b0;
         done_q    <= 1'b0;  err_q    <= 1'b0; s_ready_q <= 1'b0;
         tw_addr_q <= '0;    m_valid_q <= 1'b0; m_last_q <= 1'b0;
         m_re_q    <= '0;    m_im_q   <= '0;   m_k_q    <= '0;
         v1_q      <= 1'b0;  f1_q     <= 1'b0; v2_q     <= 1'b0;
         f2_q      <= 1'b0;  prod_re_q <= '0;  prod_im_q <= '0;
         acc_re_q  <= '0;    acc_im_q <= '0;
      end else begin
         st_q      <= st_d;      n_q      <= n_d;      inv_q    <= inv_d;
         k_q       <= k_d;       cnt_q    <= cnt_d;    busy_q   <= busy_d;
         done_q    <= done_d;    err_q    <= err_d;    s_ready_q <= s_ready_d;
         tw_addr_q <= tw_addr_d; m_valid_q <= m_valid_d; m_last_q <= m_last_d;
         m_re_q    <= m_re_d;    m_im_q   <= m_im_d;   m_k_q    <= m_k_d;
         v1_q      <= v1_d;      f1_q     <= f1_d;     v2_q     <= v2_d;
         f2_q      <= f2_d;      prod_re_q <= prod_re_d; prod_im_q <= prod_im_d;
         acc_re_q  <= acc_re_d;  acc_im_q <= acc_im_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign s_ready = s_ready_q;
   assign tw_addr = tw_addr_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_re    = m_re_q;
   assign m_im    = m_im_q;
   assign m_k     = m_k_q;
endmodule

// File: tb/tb_dft_mac_engine.sv
// Bench for dft_mac_engine: directed and random DFT jobs against a plain-arithmetic DFT model.
module tb_dft_mac_engine;
   localparam int  DW   = 16;
   localparam int  NLOG = 12;
   localparam real PI   = 3.14159265358979323846;

   logic                 clk = 1'b0;
   logic                 n_Reset;
   logic [NLOG:0]        cfg_n;
   logic                 cfg_inverse, start, busy, done, err;
   logic                 s_valid, s_ready;
   logic signed [DW-1:0] s_re, s_im;
   logic [NLOG-1:0]      tw_addr;
   logic signed [DW-1:0] tw_re = '0, tw_im = '0;
   logic                 m_valid, m_ready, m_last;
   logic signed [DW-1:0] m_re, m_im;
   logic [NLOG-1:0]      m_k;

   int     n_checks = 0, n_pass = 0, cur_n = 4;
   int     xr [32], xi [32];
   longint exp_re [32], exp_im [32], got_re [32], got_im [32];

   dft_mac_engine #(.DW(DW), .NLOG(NLOG)) dut (
      .clk(clk), .n_Reset(n_Reset), .cfg_n(cfg_n), .cfg_inverse(cfg_inverse),
      .start(start), .busy(busy), .done(done), .err(err),
      .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
      .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
      .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
      .m_k(m_k), .m_last(m_last));

   always #5 clk = ~clk;

   function automatic int rnd_real(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction
   function automatic int rom_re(input int a, input int n);
      return rnd_real(32767.0 * $cos(2.0 * PI * a / n));
   endfunction
   function automatic int rom_im(input int a, input int n);
      return -rnd_real(32767.0 * $sin(2.0 * PI * a / n));
   endfunction

   // External twiddle ROM with one cycle of read latency.
   always @(posedge clk) begin
      tw_re <= 16'(rom_re(int'(tw_addr), cur_n));
      tw_im <= 16'(rom_im(int'(tw_addr), cur_n));
   end

   task automatic check(input string tag, input longint got, input longint want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
   endtask

   function automatic longint sat_rnd(input longint a);
      longint r;
      r = (a + 16384) >>> 15;
      if (r > 32767)  return 32767;
      if (r < -32768) return -32768;
      return r;
   endfunction

   task automatic model(input int n, input bit inv);
      for (int k = 0; k < n; k++) begin
         longint ar, ai, wr, wi;
         ar = 0; ai = 0;
         for (int t = 0; t < n; t++) begin
            wr = rom_re((k * t) % n, n);
            wi = rom_im((k * t) % n, n);
            if (inv) wi = -wi;
            ar += longint'(xr[t]) * wr - longint'(xi[t]) * wi;
            ai += longint'(xr[t]) * wi + longint'(xi[t]) * wr;
         end
         exp_re[k] = sat_rnd(ar);
         exp_im[k] = sat_rnd(ai);
      end
   endtask

   function automatic longint all_out();
      return longint'({busy, done, err, s_ready, m_valid, m_last, m_re, m_im, m_k, tw_addr});
   endfunction
   function automatic longint out_snap();
      return longint'({m_valid, m_last, m_re, m_im, m_k, tw_addr});
   endfunction

   task automatic set_x(input int a0, input int a1, input int a2, input int a3);
      xr[0] = a0; xr[1] = a1; xr[2] = a2; xr[3] = a3;
      for (int i = 0; i < 4; i++) xi[i] = 0;
   endtask

   task automatic rand_x(input int n);
      for (int i = 0; i < n; i++) begin
         xr[i] = int'($urandom_range(0, 65535)) - 32768;
         xi[i] = int'($urandom_range(0, 65535)) - 32768;
      end
   endtask

   // A start pulse with different settings on the first LOAD cycle must be ignored.
   task automatic start_feed(input int n, input bit inv, input bit glitch);
      int i, guard;
      bit took;
      cur_n = n;
      @(negedge clk);
      cfg_n = (NLOG+1)'(n); cfg_inverse = inv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", longint'(busy), 1);
      i = 0; guard = 0;
      while (i < n && guard < 2000) begin
         if (glitch && guard == 0) begin
            start = 1'b1; cfg_n = (NLOG+1)'(n + 1); cfg_inverse = !inv;
         end else start = 1'b0;
         s_valid = ($urandom_range(0, 3) != 0);
         s_re = 16'(xr[i]); s_im = 16'(xi[i]);
         took = s_valid && s_ready;
         @(negedge clk);
         guard++;
         if (took) i++;
      end
      start = 1'b0; s_valid = 1'b0;
      check("load_count", i, n);
   endtask

   task automatic collect(input int n, input int stall_bin);
      int kk, guard;
      bit stalled, stable;
      longint snap;
      kk = 0; guard = 0; stalled = 0;
      while (kk < n && guard < 5000) begin
         m_ready = ($urandom_range(0, 2) != 0);
         if (m_valid && kk == stall_bin && !stalled) begin
            m_ready = 1'b0; stable = 1'b1; snap = out_snap();
            repeat (10) begin
               @(negedge clk);
               if (out_snap() !== snap) stable = 1'b0;
            end
            check("stall_hold", longint'(stable), 1);
            stalled = 1'b1; m_ready = 1'b1;
         end
         if (m_valid && m_ready) begin
            check("bin_re", longint'(m_re), exp_re[kk]);
            check("bin_im", longint'(m_im), exp_im[kk]);
            check("bin_k", longint'(m_k), kk);
            check("bin_last", longint'(m_last), longint'(kk == n - 1));
            got_re[kk] = longint'(m_re); got_im[kk] = longint'(m_im);
            kk++;
         end
         @(negedge clk);
         guard++;
      end
      m_ready = 1'b0;
      check("bin_count", kk, n);
      check("done_pulse", longint'(done), 1);
      check("busy_clear", longint'(busy), 0);
      @(negedge clk);
      check("done_single", longint'(done), 0);
   endtask

   task automatic run_job(input int n, input bit inv, input bit glitch, input int stall_bin);
      model(n, inv);
      start_feed(n, inv, glitch);
      collect(n, stall_bin);
   endtask

   initial begin
      int bad [3];
      bad = '{0, 1, 4097};
      n_Reset = 1'b0; start = 1'b0; cfg_n = '0; cfg_inverse = 1'b0;
      s_valid = 1'b0; s_re = '0; s_im = '0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", all_out(), 0);
      n_Reset = 1'b1;

      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         cfg_n = (NLOG+1)'(bad[b]); start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("err_pulse", longint'(err), 1);
         check("err_busy", longint'(busy), 0);
         @(negedge clk);
         check("err_single", longint'(err), 0);
      end

      set_x(16384, 0, 0, 0);
      run_job(4, 1'b0, 1'b1, 1);
      check("impulse_bin3_re", got_re[3], 16384);

      set_x(8192, 0, -8192, 0);
      run_job(4, 1'b0, 1'b0, -1);
      check("alt_bin1_re", got_re[1], 16384);
      check("alt_bin2_re", got_re[2], 0);

      set_x(16384, 16384, 16384, 16384);
      run_job(4, 1'b0, 1'b0, -1);
      check("dc_bin0_sat", got_re[0], 32767);
      check("dc_bin1_re", got_re[1], 0);

      set_x(0, 16384, 0, 0);
      run_job(4, 1'b0, 1'b0, 2);
      check("fwd_bin1_im", got_im[1], -16383);
      run_job(4, 1'b1, 1'b0, -1);
      check("inv_bin1_im", got_im[1], 16384);

      rand_x(8);
      start_feed(8, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      n_Reset = 1'b0;
      @(negedge clk);
      check("reset_mid_calc", all_out(), 0);
      @(negedge clk);
      check("reset_hold", all_out(), 0);
      n_Reset = 1'b1;
      rand_x(8);
      run_job(8, 1'b0, 1'b0, -1);

      repeat (8) begin
         int n;
         bit inv;
         n   = int'($urandom_range(2, 16));
         inv = 1'($urandom_range(0, 1));
         rand_x(n);
         run_job(n, inv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)) - 4);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_checks);
      $fatal(1);
   end
endmodule
